// File: rtl/itof_arb_pkg.sv
// Shared types and the round-robin pick function for the itof sharing arbiter.
// Optional feature macro used by the top: ITOF_ARB_PERF_EN (performance counters).
package itof_arb_pkg;

    // Upper bound on the requester count; sizes the generic pick function and tag index.
    localparam int MAX_REQ = 8;
    localparam int MAX_IDW = 3;

    typedef logic [31:0] word_t;

    // One entry of the in-flight tag line: valid bit plus originating requester index.
    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] idx;
    } tag_t;

    // Round-robin pick: one-hot grant for the first valid requester at or after ptr,
    // wrapping modulo nreq. Bits at and above nreq are never set.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [MAX_IDW-1:0] ptr,
        input int                 nreq
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = '0;
        found = 1'b0;
        for (int off = 0; off < MAX_REQ; off++) begin
            idx = (int'(ptr) + off) % nreq;
            if (off < nreq && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/itof_arb_tagline.sv
// Valid/index delay line of depth NSTAGE+1 that follows each issued operand through
// the shared converter, so the result can be steered back to its originator.
module itof_arb_tagline
    import itof_arb_pkg::*;
#(
    parameter int NSTAGE = 2
) (
    input  logic clk,
    input  logic rstn,
    input  tag_t tag_in,
    output tag_t tag_last,
    output logic busy
);

    // Stage 0 captures the issue; stages 1..NSTAGE track the converter pipeline.
    tag_t tag_pn [NSTAGE+1];

    // Shift the tag line every cycle; reset discards anything in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i <= NSTAGE; i++) begin
                tag_pn[i] <= '0;
            end
        end else begin
            tag_pn[0] <= tag_in;
            for (int i = 1; i <= NSTAGE; i++) begin
                tag_pn[i] <= tag_pn[i-1];
            end
        end
    end

    // Busy while any stage holds a live operation.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= NSTAGE; i++) begin
            busy = busy | tag_pn[i].valid;
        end
    end

    assign tag_last = tag_pn[NSTAGE];

endmodule

// File: rtl/itof_share_arb.sv
// Round-robin arbiter time-sharing one pipelined int32->float converter among NREQ
// requesters. One issue per cycle, no backpressure; results return in issue order.
// Optional: define ITOF_ARB_PERF_EN to add perf_issue / perf_stall counters.
module itof_share_arb
    import itof_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int NSTAGE = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]  req_ready,
    output logic [31:0]      itof_x,
    input  logic [31:0]      itof_y,
    output logic [NREQ-1:0]  resp_valid,
    output logic [31:0]      resp_data,
`ifdef ITOF_ARB_PERF_EN
    output logic [31:0]      perf_issue,
    output logic [31:0]      perf_stall,
`endif
    output logic             busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     ptr_next;
    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_REQ-1:0] grant_ext;
    logic [NREQ-1:0]    grant;
    logic [MAX_IDW-1:0] win_idx;
    word_t              win_data;
    logic               fire;
    tag_t               tag_in;
    tag_t               tag_last;
    logic [NREQ-1:0]    resp_onehot;
    logic               unused_grant;

    // Grant: round-robin pick from ptr, suppressed entirely while en is low.
    always_comb begin
        valid_ext = '0;
        valid_ext[NREQ-1:0] = req_valid;
        grant_ext = rr_pick(valid_ext, MAX_IDW'(ptr), NREQ);
        grant     = en ? grant_ext[NREQ-1:0] : '0;
    end

    // Bits above NREQ are always zero from rr_pick.
    assign unused_grant = ^grant_ext;
    assign req_ready    = grant;
    assign fire         = |grant;

    // Winner index and operand mux from the one-hot grant.
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_idx  = MAX_IDW'(i);
                win_data = req_data[32*i +: 32];
            end
        end
    end

    // Pointer advances to the requester after the winner, wrapping to 0.
    always_comb begin
        if (win_idx == MAX_IDW'(NREQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = IDW'(win_idx + 1'b1);
        end
    end

    // ---- issue stage (p0): operand register and round-robin pointer ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            itof_x <= '0;
            ptr    <= '0;
        end else if (fire) begin
            itof_x <= win_data;
            ptr    <= ptr_next;
        end
    end

    assign tag_in = '{valid: fire, idx: win_idx};

    itof_arb_tagline #(
        .NSTAGE (NSTAGE)
    ) u_tagline (
        .clk      (clk),
        .rstn     (rstn),
        .tag_in   (tag_in),
        .tag_last (tag_last),
        .busy     (busy)
    );

    // Decode the returning tag into the originator's one-hot response strobe.
    always_comb begin
        resp_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (tag_last.idx == MAX_IDW'(i)) begin
                resp_onehot[i] = 1'b1;
            end
        end
    end

    // ---- response stage: capture converter result when the last tag is live ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else if (tag_last.valid) begin
            resp_valid <= resp_onehot;
            resp_data  <= itof_y;
        end else begin
            resp_valid <= '0;
        end
    end

`ifdef ITOF_ARB_PERF_EN
    logic stall;

    // A stall is any cycle with a pending request but no grant, including en low.
    assign stall = (|req_valid) && !fire;

    // Free-running handshake and stall counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else begin
            if (fire) begin
                perf_issue <= perf_issue + 32'd1;
            end
            if (stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
